// File: rtl/cfg_mux_pkg.sv
// Shared types and helpers for the config-bit input mux bank.
//   state_e  : loader/commit FSM states
//   SEL_LSB  : position of the select field inside a channel field
//   ch_field : extracts channel c's field from a frame (caller truncates)
package cfg_mux_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, RUN} state_e;

  // Channel field layout: [sel | en | inv], sel at the bottom.
  // en/inv sit directly above sel, so their positions follow from SEL_W.
  localparam int SEL_LSB   = 0;

  // Helper operand widths; frames up to FRAME_MAX bits are supported.
  localparam int FRAME_MAX = 256;
  localparam int FIELD_MAX = 32;

  function automatic logic [FIELD_MAX-1:0] ch_field(input logic [FRAME_MAX-1:0] frame,
                                                    input int c, input int cbit_w);
    logic [FRAME_MAX-1:0] s;
    s = frame >> (c * cbit_w);
    return s[FIELD_MAX-1:0];
  endfunction

endpackage

// File: rtl/cfg_shift_loader.sv
// Serial frame loader: bit counter + shadow register.
//   active     : FSM is in LOAD (drives ready)
//   clr        : restart/entry clear of counter and shadow
//   din/valid  : serial bit and qualifier
//   ready      : bit accepted when valid && ready
//   restart    : clr seen while already loading
//   frame_full : accept of the last frame bit (comb pulse)
//   shadow     : frame assembled so far, bit 0 first
module cfg_shift_loader #(
  parameter int FRAME_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               active,
  input  logic               clr,
  input  logic               din,
  input  logic               valid,
  output logic               ready,
  output logic               restart,
  output logic               frame_full,
  output logic [FRAME_W-1:0] shadow
);

  localparam int CNT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

  logic [CNT_W-1:0] cnt;
  logic             accept, last;

  assign ready      = active;
  assign restart    = active && clr;
  // a clear in the same cycle discards the bit on cfg_din
  assign accept     = active && valid && !clr;
  assign last       = (cnt == CNT_W'(FRAME_W-1));
  assign frame_full = accept && last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      shadow <= '0;
    end else if (clr) begin
      cnt    <= '0;
      shadow <= '0;
    end else if (accept) begin
      shadow[cnt] <= din;
      cnt         <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cfg_inmux_bank.sv
// Config-frame loader plus NUM_CH registered N:1 muxes with enable/invert.
//   cfg_start/cfg_din/cfg_valid : frame load control and serial data
//   cfg_ready/cfg_done/cfg_err  : LOAD, RUN, restart pulse / sticky bad-select
//   prog        : high whenever not in RUN (muxes forced to 0)
//   cbit/cbitb  : committed frame and its complement
//   min/muxo    : mux inputs (channel c at [c*NUM_IN +: NUM_IN]) and outputs
module cfg_inmux_bank
  import cfg_mux_pkg::*;
#(
  parameter  int NUM_CH  = 4,
  parameter  int NUM_IN  = 16,
  parameter  int SEL_W   = 4,
  localparam int CBIT_W  = SEL_W + 2,
  localparam int FRAME_W = NUM_CH * CBIT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_start,
  input  logic                     cfg_din,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  output logic                     cfg_done,
  output logic                     cfg_err,
  output logic                     prog,
  output logic [FRAME_W-1:0]       cbit,
  output logic [FRAME_W-1:0]       cbitb,
  input  logic [NUM_CH*NUM_IN-1:0] min,
  output logic [NUM_CH-1:0]        muxo
);

  localparam int EN_BIT  = SEL_LSB + SEL_W;
  localparam int INV_BIT = EN_BIT + 1;
  localparam int PAD_W   = 2**SEL_W;

  state_e             state;
  logic [FRAME_W-1:0] cbit_q, shadow;
  logic [NUM_CH-1:0]  ill_ch, mux_d;
  logic               start_ok, restart, frame_full;

  // cfg_start is ignored only while committing
  assign start_ok = cfg_start && (state != COMMIT);

  cfg_shift_loader #(.FRAME_W(FRAME_W)) u_ld (
    .clk        (clk),
    .rst_n      (rst_n),
    .active     (state == LOAD),
    .clr        (start_ok),
    .din        (cfg_din),
    .valid      (cfg_valid),
    .ready      (cfg_ready),
    .restart    (restart),
    .frame_full (frame_full),
    .shadow     (shadow)
  );

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CBIT_W-1:0] sf, cf;
    logic [PAD_W-1:0]  pad;
    assign sf = CBIT_W'(ch_field(FRAME_MAX'(shadow), c, CBIT_W));
    assign cf = CBIT_W'(ch_field(FRAME_MAX'(cbit_q), c, CBIT_W));
    assign ill_ch[c] = sf[EN_BIT] && (int'(sf[SEL_LSB +: SEL_W]) >= NUM_IN);
    // zero-pad so any sel value indexes safely; out-of-range sel is gated anyway
    assign pad = PAD_W'(min[c*NUM_IN +: NUM_IN]);
    assign mux_d[c] = cf[EN_BIT] && (int'(cf[SEL_LSB +: SEL_W]) < NUM_IN) &&
                      (pad[cf[SEL_LSB +: SEL_W]] ^ cf[INV_BIT]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cbit_q  <= '0;
      muxo    <= '0;
      cfg_err <= 1'b0;
    end else begin
      // leaving RUN forces 0 immediately so muxo is never live while prog=1
      muxo <= (state == RUN && !cfg_start) ? mux_d : '0;
      case (state)
        IDLE:   if (cfg_start) state <= LOAD;
        LOAD: begin
          cfg_err <= restart;
          if (frame_full) state <= COMMIT;
        end
        COMMIT: begin
          cbit_q  <= shadow;
          cfg_err <= |ill_ch;
          state   <= RUN;
        end
        RUN: if (cfg_start) begin
          state   <= LOAD;
          cfg_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cbit     = cbit_q;
  assign cbitb    = ~cbit_q;
  assign prog     = (state != RUN);
  assign cfg_done = (state == RUN);

endmodule

// File: tb/tb_cfg_inmux_bank.sv
module tb_cfg_inmux_bank;

  localparam int NUM_CH = 2, NUM_IN = 12, SEL_W = 4, FRAME_W = 12;

  logic                     clk = 1'b0, rst_n = 1'b0;
  logic                     cfg_start = 1'b0, cfg_din = 1'b0, cfg_valid = 1'b0;
  logic                     cfg_ready, cfg_done, cfg_err, prog;
  logic [FRAME_W-1:0]       cbit, cbitb;
  logic [NUM_CH*NUM_IN-1:0] min = '0;
  logic [NUM_CH-1:0]        muxo;

  int npass = 0, ntotal = 0;

  cfg_inmux_bank #(.NUM_CH(NUM_CH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_din(cfg_din),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_done(cfg_done),
    .cfg_err(cfg_err), .prog(prog), .cbit(cbit), .cbitb(cbitb),
    .min(min), .muxo(muxo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time bound expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // shift f in LSB first; with gaps, an idle (valid=0, inverted data) cycle precedes each bit
  task automatic load_frame(input logic [FRAME_W-1:0] f, input bit gaps);
    for (int i = 0; i < FRAME_W; i++) begin
      if (gaps) begin
        cfg_valid = 1'b0; cfg_din = ~f[i]; tick();
      end
      chk("ready_in_load", 32'(cfg_ready), 32'd1);
      cfg_valid = 1'b1; cfg_din = f[i]; tick();
    end
    cfg_valid = 1'b0; cfg_din = 1'b0;
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
  endtask

  initial begin
    // 1. reset + idle
    #12 rst_n = 1'b1;
    repeat (5) tick();
    chk("rst_prog",  32'(prog),      32'd1);
    chk("rst_cbit",  32'(cbit),      32'h000);
    chk("rst_cbitb", 32'(cbitb),     32'hFFF);
    chk("rst_muxo",  32'(muxo),      32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    chk("rst_done",  32'(cfg_done),  32'd0);
    chk("rst_err",   32'(cfg_err),   32'd0);

    // 2. ch0 en sel3 inv0, ch1 en sel11 inv1
    min = '0; min[3] = 1'b1; min[23] = 1'b1;
    pulse_start();
    chk("load_prog", 32'(prog), 32'd1);
    load_frame(12'hED3, 1'b0);
    chk("commit_ready", 32'(cfg_ready), 32'd0);
    chk("commit_prog",  32'(prog),      32'd1);
    chk("commit_cbit",  32'(cbit),      32'h000);
    tick();
    chk("run1_prog",  32'(prog),     32'd0);
    chk("run1_done",  32'(cfg_done), 32'd1);
    chk("run1_cbit",  32'(cbit),     32'hED3);
    chk("run1_cbitb", 32'(cbitb),    32'h12C);
    chk("run1_muxo",  32'(muxo),     32'h0);
    tick();
    chk("run2_muxo", 32'(muxo), 32'h1);
    chk("run2_err",  32'(cfg_err), 32'd0);
    min[3] = 1'b0; tick();
    chk("min3_low_muxo", 32'(muxo), 32'h0);

    // 3/5. reload from RUN with ch0 sel=13 (illegal), cbit holds through LOAD
    pulse_start();
    chk("reload_prog",  32'(prog),     32'd1);
    chk("reload_done",  32'(cfg_done), 32'd0);
    chk("reload_muxo",  32'(muxo),     32'h0);
    chk("reload_cbit",  32'(cbit),     32'hED3);
    min = 24'h7FFFFF;
    load_frame(12'hEDD, 1'b0);
    chk("commit2_cbit", 32'(cbit), 32'hED3);
    chk("commit2_err",  32'(cfg_err), 32'd0);
    tick();
    chk("ill_cbit", 32'(cbit),    32'hEDD);
    chk("ill_err",  32'(cfg_err), 32'd1);
    tick();
    chk("ill_muxo", 32'(muxo), 32'h2);
    repeat (3) tick();
    chk("ill_err_sticky", 32'(cfg_err), 32'd1);
    pulse_start();
    chk("err_cleared", 32'(cfg_err), 32'd0);
    chk("load_muxo0",  32'(muxo),    32'h0);

    // 4. restart after 7 bits; discarded bit in restart cycle
    cfg_valid = 1'b1; cfg_din = 1'b1;
    repeat (7) tick();
    cfg_start = 1'b1; tick();
    cfg_start = 1'b0; cfg_valid = 1'b0;
    chk("restart_err",   32'(cfg_err),   32'd1);
    chk("restart_ready", 32'(cfg_ready), 32'd1);
    tick();
    chk("restart_err_pulse", 32'(cfg_err), 32'd0);
    min = 24'h7FFFDF;
    load_frame(12'h035, 1'b0);
    chk("restart_commit_ready", 32'(cfg_ready), 32'd0);
    tick();
    chk("restart_cbit", 32'(cbit),    32'h035);
    chk("restart_noerr", 32'(cfg_err), 32'd0);
    tick();
    chk("restart_muxo", 32'(muxo), 32'h1);

    // cfg_start coincident with the final bit: restart wins
    pulse_start();
    cfg_valid = 1'b1; cfg_din = 1'b0;
    repeat (11) tick();
    cfg_start = 1'b1; cfg_din = 1'b1; tick();
    cfg_start = 1'b0; cfg_valid = 1'b0;
    chk("final_race_ready", 32'(cfg_ready), 32'd1);
    chk("final_race_err",   32'(cfg_err),   32'd1);
    chk("final_race_cbit",  32'(cbit),      32'h035);

    // 6. async reset mid-LOAD, between edges
    cfg_valid = 1'b1; cfg_din = 1'b1;
    repeat (3) tick();
    cfg_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_prog",  32'(prog),      32'd1);
    chk("arst_ready", 32'(cfg_ready), 32'd0);
    chk("arst_done",  32'(cfg_done),  32'd0);
    chk("arst_cbit",  32'(cbit),      32'h000);
    chk("arst_cbitb", 32'(cbitb),     32'hFFF);
    chk("arst_muxo",  32'(muxo),      32'h0);
    chk("arst_err",   32'(cfg_err),   32'd0);
    #1 rst_n = 1'b1;
    tick();
    chk("post_arst_idle", 32'(cfg_ready), 32'd0);

    // gapped load gives the same cbit as gap-free
    pulse_start();
    load_frame(12'hED3, 1'b1);
    tick();
    chk("gap_cbit",  32'(cbit),     32'hED3);
    chk("gap_cbitb", 32'(cbitb),    32'h12C);
    chk("gap_done",  32'(cfg_done), 32'd1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
